// File: rtl/nibble_serial_cmp_ctrl.sv
// Serial WIDTH-bit magnitude compare through one external 4-bit cascadable
// comparator slice. Nibbles are walked LSB->MSB, one per clock, and the
// cascade is registered between steps.
module nibble_serial_cmp_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             ARST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Y,
  output logic             cmp_err,
  output logic [3:0]       cmp_A,
  output logic [3:0]       cmp_B,
  output logic             cmp_Li,
  output logic             cmp_Ei,
  output logic             cmp_Gi,
  input  logic             cmp_Lo,
  input  logic             cmp_Eo,
  input  logic             cmp_Go
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("nibble_serial_cmp_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDXW-1:0]       r_idx, w_idx_nxt;
  logic                  r_l, r_e, r_g, w_l_nxt, w_e_nxt, w_g_nxt;
  logic [NIB-1:0][3:0]   r_a, r_b, w_a_nxt, w_b_nxt;
  logic [1:0]            r_op, w_op_nxt;
  logic                  r_signed, w_signed_nxt;
  logic                  r_y, w_y_nxt;
  logic                  r_err, w_err_nxt;

  logic                  w_last;
  logic                  w_flip;
  logic                  w_onehot;
  logic [3:0]            w_nib_a, w_nib_b;

  assign w_last   = (r_idx == IDXW'(NIB - 1));
  // Signed operands become offset-binary by flipping the sign bit, which only
  // ever lives in the top nibble.
  assign w_flip   = r_signed && w_last;
  assign w_nib_a  = r_a[r_idx];
  assign w_nib_b  = r_b[r_idx];
  assign w_onehot = ({cmp_Lo, cmp_Eo, cmp_Go} == 3'b100) ||
                    ({cmp_Lo, cmp_Eo, cmp_Go} == 3'b010) ||
                    ({cmp_Lo, cmp_Eo, cmp_Go} == 3'b001);

  assign busy    = (r_state == StRun);
  assign done    = (r_state == StDone);
  assign Y       = r_y;
  assign cmp_err = r_err;

  // Outside RUN the slice is fed a neutral "equal" pattern.
  assign cmp_A  = busy ? {w_nib_a[3] ^ w_flip, w_nib_a[2:0]} : 4'h0;
  assign cmp_B  = busy ? {w_nib_b[3] ^ w_flip, w_nib_b[2:0]} : 4'h0;
  assign cmp_Li = busy ? r_l : 1'b0;
  assign cmp_Ei = busy ? r_e : 1'b1;
  assign cmp_Gi = busy ? r_g : 1'b0;

  // Next-state: accept start, step through nibbles, resolve result.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_l_nxt      = r_l;
    w_e_nxt      = r_e;
    w_g_nxt      = r_g;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_op_nxt     = r_op;
    w_signed_nxt = r_signed;
    w_y_nxt      = r_y;
    w_err_nxt    = r_err;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_a_nxt      = A;
          w_b_nxt      = B;
          w_op_nxt     = op;
          w_signed_nxt = is_signed;
          w_idx_nxt    = '0;
          w_l_nxt      = 1'b0;
          w_e_nxt      = 1'b1;
          w_g_nxt      = 1'b0;
          w_err_nxt    = 1'b0;
          w_state_nxt  = StRun;
        end else if (r_state == StDone) begin
          w_state_nxt = StIdle;
        end
      end
      StRun: begin
        w_l_nxt = cmp_Lo;
        w_e_nxt = cmp_Eo;
        w_g_nxt = cmp_Go;
        if (!w_onehot) begin
          w_err_nxt = 1'b1;
        end
        if (w_last) begin
          w_state_nxt = StDone;
          unique case (r_op)
            2'b00: w_y_nxt = cmp_Lo;
            2'b01: w_y_nxt = cmp_Go;
            2'b10: w_y_nxt = !cmp_Go;
            2'b11: w_y_nxt = !cmp_Lo;
          endcase
        end else begin
          w_idx_nxt = r_idx + IDXW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous abort.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_l      <= 1'b0;
      r_e      <= 1'b1;
      r_g      <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 2'b00;
      r_signed <= 1'b0;
      r_y      <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_l      <= w_l_nxt;
      r_e      <= w_e_nxt;
      r_g      <= w_g_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_op     <= w_op_nxt;
      r_signed <= w_signed_nxt;
      r_y      <= w_y_nxt;
      r_err    <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_nibble_serial_cmp_ctrl.sv
// Directed bench for nibble_serial_cmp_ctrl with a behavioural 74HC85 slice
// and a scoreboard of expected results.
module tb_nibble_serial_cmp_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             CLK = 1'b0;
  logic             ARST = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic             is_signed = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             busy, done, Y, cmp_err;
  logic [3:0]       cmp_A, cmp_B;
  logic             cmp_Li, cmp_Ei, cmp_Gi;
  logic             cmp_Lo, cmp_Eo, cmp_Go;

  nibble_serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .ARST(ARST), .start(start), .op(op), .is_signed(is_signed),
    .A(A), .B(B), .busy(busy), .done(done), .Y(Y), .cmp_err(cmp_err),
    .cmp_A(cmp_A), .cmp_B(cmp_B), .cmp_Li(cmp_Li), .cmp_Ei(cmp_Ei), .cmp_Gi(cmp_Gi),
    .cmp_Lo(cmp_Lo), .cmp_Eo(cmp_Eo), .cmp_Go(cmp_Go)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int step = 0;
  bit inject = 1'b0;
  logic last_y = 1'b0;

  typedef struct {
    logic y;
    logic err;
  } exp_t;
  exp_t sb[$];

  // Step counter equals the DUT's nibble index during RUN.
  always @(posedge CLK) step <= busy ? step + 1 : 0;

  // Behavioural 74HC85: equal nibbles pass the cascade through.
  always_comb begin
    {cmp_Lo, cmp_Eo, cmp_Go} = {cmp_Li, cmp_Ei, cmp_Gi};
    if (cmp_A > cmp_B) {cmp_Lo, cmp_Eo, cmp_Go} = 3'b001;
    else if (cmp_A < cmp_B) {cmp_Lo, cmp_Eo, cmp_Go} = 3'b100;
    if (inject && step == 2) {cmp_Lo, cmp_Eo, cmp_Go} = 3'b110;
  end

  function automatic logic ref_y(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [1:0] o, input logic s);
    logic lt_v, gt_v;
    if (s) begin
      lt_v = $signed(a) < $signed(b);
      gt_v = $signed(a) > $signed(b);
    end else begin
      lt_v = a < b;
      gt_v = a > b;
    end
    case (o)
      2'b00:   return lt_v;
      2'b01:   return gt_v;
      2'b10:   return !gt_v;
      default: return !lt_v;
    endcase
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a request at a negedge and record its expected outcome.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] o, input logic s, input bit inj);
    exp_t e;
    A = a;
    B = b;
    op = o;
    is_signed = s;
    inject = inj;
    start = 1'b1;
    e.y = ref_y(a, b, o, s);
    e.err = inj;
    sb.push_back(e);
  endtask

  // Step past the accepting edge, then scramble inputs the DUT must ignore.
  task automatic finish_start();
    @(negedge CLK);
    start = 1'b0;
    A = WIDTH'($urandom);
    B = WIDTH'($urandom);
    op = 2'($urandom);
    is_signed = 1'($urandom);
  endtask

  // k0 = edges already elapsed since the accepting edge.
  task automatic wait_done(input string tag, input int k0);
    int k;
    bit seen;
    exp_t e;
    k = k0;
    seen = 1'b0;
    while (k <= int'(NIB) + 2 && !seen) begin
      if (done) begin
        seen = 1'b1;
        chkn({tag, "_latency"}, k, NIB);
        chk1({tag, "_busy_low"}, busy, 1'b0);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk1({tag, "_Y"}, Y, e.y);
          chk1({tag, "_err"}, cmp_err, e.err);
          last_y = e.y;
        end else begin
          chkn({tag, "_sb_empty"}, 0, 1);
        end
      end else begin
        if (k < int'(NIB)) begin
          chk1({tag, "_busy"}, busy, 1'b1);
          chk1({tag, "_Yhold"}, Y, last_y);
        end
        @(negedge CLK);
        k++;
      end
    end
    if (!seen) chkn({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [1:0] o, input logic s, input bit inj);
    issue(a, b, o, s, inj);
    finish_start();
    wait_done(tag, 0);
  endtask

  initial begin
    bit seen_done;

    // Reset state
    @(negedge CLK);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_Y", Y, 1'b0);
    chk1("rst_err", cmp_err, 1'b0);
    chkn("rst_cmpA", int'(cmp_A), 0);
    chk1("rst_Ei", cmp_Ei, 1'b1);
    chk1("rst_Li", cmp_Li, 1'b0);
    ARST = 1'b0;
    @(negedge CLK);

    // Basic unsigned compare, done is a single cycle
    run("lt_1234", 16'h1234, 16'h1235, 2'b00, 1'b0, 1'b0);
    @(negedge CLK);
    chk1("done_fall", done, 1'b0);
    chk1("idle_busy", busy, 1'b0);

    run("gt_1234", 16'h1234, 16'h1235, 2'b01, 1'b0, 1'b0);
    run("beef_lt", 16'hBEEF, 16'hBEEF, 2'b00, 1'b0, 1'b0);
    run("beef_gt", 16'hBEEF, 16'hBEEF, 2'b01, 1'b0, 1'b0);
    run("beef_le", 16'hBEEF, 16'hBEEF, 2'b10, 1'b0, 1'b0);
    run("beef_ge", 16'hBEEF, 16'hBEEF, 2'b11, 1'b0, 1'b0);

    // Signed vs unsigned ordering
    run("s_lt_8000", 16'h8000, 16'h0001, 2'b00, 1'b1, 1'b0);
    run("u_lt_8000", 16'h8000, 16'h0001, 2'b00, 1'b0, 1'b0);
    run("s_gt_ffff", 16'hFFFF, 16'hFFFE, 2'b01, 1'b1, 1'b0);

    // Start during RUN is ignored
    issue(16'h0005, 16'h0003, 2'b01, 1'b0, 1'b0);
    finish_start();
    @(negedge CLK);
    A = 16'h0000;
    B = 16'hFFFF;
    op = 2'b00;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done("mid_start", 2);

    // Start in the DONE cycle chains with no idle cycle
    chk1("chain_in_done", done, 1'b1);
    run("chain", 16'h00A0, 16'h00A0, 2'b11, 1'b0, 1'b0);

    // Asynchronous abort in the third RUN cycle
    issue(16'h0100, 16'h0200, 2'b01, 1'b0, 1'b0);
    finish_start();
    @(negedge CLK);
    @(negedge CLK);
    ARST = 1'b1;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_Y", Y, 1'b0);
    chk1("arst_done", done, 1'b0);
    void'(sb.pop_back());
    last_y = 1'b0;
    @(negedge CLK);
    ARST = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (done) seen_done = 1'b1;
    end
    chk1("arst_no_done", seen_done, 1'b0);
    run("post_arst", 16'h0010, 16'h0001, 2'b01, 1'b0, 1'b0);

    // Non-one-hot slice output sets the sticky error; next start clears it
    run("inject", 16'h1111, 16'h1111, 2'b10, 1'b0, 1'b1);
    run("err_clear", 16'h0001, 16'h0002, 2'b11, 1'b0, 1'b0);

    chkn("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
